// File: rtl/wb_regfile_pkg.sv
// Shared widths and constants for the writeback register file and its scoreboard.
package wb_regfile_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned PEND_W   = 2;
  localparam logic [AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters feeding the ID-stage hazard check.
module wb_scoreboard
  import wb_regfile_pkg::AW;
  import wb_regfile_pkg::ZERO_REG;
#(
  parameter int unsigned NREG   = wb_regfile_pkg::NREG,
  parameter int unsigned PEND_W = wb_regfile_pkg::PEND_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          RegWrite,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          sb_overflow
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] r_cnt [NREG];
  logic              r_ovf;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;
  logic              w_hit1;
  logic              w_hit2;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      w_inc[r] = issue_valid && (issue_rd == AW'(r));
      w_dec[r] = RegWrite && (rd_addr == AW'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          if (r_cnt[r] == CNT_MAX) r_ovf <= 1'b1;
          else                     r_cnt[r] <= r_cnt[r] + 1'b1;
        end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  assign w_hit1 = RegWrite && (rd_addr == rs1_addr) && (rs1_addr != ZERO_REG);
  assign w_hit2 = RegWrite && (rd_addr == rs2_addr) && (rs2_addr != ZERO_REG);

  // cnt > hit equals (cnt - hit) != 0 without wrapping when an untracked writer hits cnt==0.
  assign rs1_busy    = r_cnt[rs1_addr] > PEND_W'(w_hit1);
  assign rs2_busy    = r_cnt[rs2_addr] > PEND_W'(w_hit2);
  assign sb_overflow = r_ovf;
endmodule

// File: rtl/wb_regfile.sv
// 32x32 integer register file: WB write port, ID read ports with same-cycle bypass.
module wb_regfile
  import wb_regfile_pkg::AW;
  import wb_regfile_pkg::ZERO_REG;
#(
  parameter int unsigned XLEN   = wb_regfile_pkg::XLEN,
  parameter int unsigned NREG   = wb_regfile_pkg::NREG,
  parameter int unsigned PEND_W = wb_regfile_pkg::PEND_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            RegWrite,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] Write_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            sb_overflow
);
  logic [XLEN-1:0] r_regs [NREG];
  logic            w_we;

  assign w_we = RegWrite && (rd_addr != ZERO_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) r_regs[r] <= '0;
    end else if (w_we) begin
      r_regs[rd_addr] <= Write_data;
    end
  end

  always_comb begin
    rs1_data = r_regs[rs1_addr];
    if (rs1_addr == ZERO_REG)                  rs1_data = '0;
    else if (w_we && (rd_addr == rs1_addr))    rs1_data = Write_data;
    rs2_data = r_regs[rs2_addr];
    if (rs2_addr == ZERO_REG)                  rs2_data = '0;
    else if (w_we && (rd_addr == rs2_addr))    rs2_data = Write_data;
  end

  wb_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .RegWrite    (RegWrite),
    .rd_addr     (rd_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .sb_overflow (sb_overflow)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized checks of wb_regfile against an array-based reference model.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, Write_data;
  logic        RegWrite, issue_valid;
  logic        rs1_busy, rs2_busy, sb_overflow;

  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_ovf;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .RegWrite    (RegWrite),
    .rd_addr     (rd_addr),
    .Write_data  (Write_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .sb_overflow (sb_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] exp_data(input int a);
    if (a == 0) return '0;
    if (RegWrite && int'(rd_addr) == a) return Write_data;
    return m_reg[a];
  endfunction

  function automatic logic [31:0] exp_busy(input int a);
    int d;
    d = (RegWrite && int'(rd_addr) == a && a != 0) ? 1 : 0;
    return {31'b0, (m_cnt[a] - d) > 0};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".rs1_data"}, rs1_data, exp_data(int'(rs1_addr)));
    chk({tag, ".rs2_data"}, rs2_data, exp_data(int'(rs2_addr)));
    chk({tag, ".rs1_busy"}, {31'b0, rs1_busy}, exp_busy(int'(rs1_addr)));
    chk({tag, ".rs2_busy"}, {31'b0, rs2_busy}, exp_busy(int'(rs2_addr)));
    chk({tag, ".ovf"}, {31'b0, sb_overflow}, {31'b0, m_ovf});
  endtask

  task automatic set_in(input bit rw, input int rd, input logic [31:0] wd,
                        input bit iv, input int ird, input int a1, input int a2);
    RegWrite    = rw;
    rd_addr     = 5'(rd);
    Write_data  = wd;
    issue_valid = iv;
    issue_rd    = 5'(ird);
    rs1_addr    = 5'(a1);
    rs2_addr    = 5'(a2);
  endtask

  // Model advances on the same rising edge the DUT samples; inputs are held stable across it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int r = 1; r < 32; r++) begin
        bit inc, dec;
        inc = issue_valid && int'(issue_rd) == r;
        dec = RegWrite && int'(rd_addr) == r;
        if (inc && !dec) begin
          if (m_cnt[r] == 3) m_ovf = 1'b1;
          else               m_cnt[r]++;
        end else if (dec && !inc && m_cnt[r] > 0) begin
          m_cnt[r]--;
        end
      end
      if (RegWrite && rd_addr != 0) m_reg[rd_addr] = Write_data;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, '0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      set_in(0, 0, '0, 0, 0, a, 31 - a);
      #1 check_all("read_all");
      chk("read_all.zero", rs1_data | rs2_data, 32'h0);
    end
    @(negedge clk);

    set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    #1 check_all("wr_x5");
    tick();
    set_in(0, 0, '0, 0, 0, 5, 0);
    #1 chk("rd_x5", rs1_data, 32'hDEADBEEF);
    check_all("rd_x5");
    set_in(1, 0, 32'h1234, 0, 0, 0, 0);
    tick();
    set_in(0, 0, '0, 0, 0, 5, 0);
    #1 chk("wr_x0.rs2", rs2_data, 32'h0);

    set_in(1, 7, 32'h11, 0, 0, 0, 0);
    tick();
    set_in(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);
    #1 chk("bypass.rs1", rs1_data, 32'hA5A5A5A5);
    chk("bypass.rs2", rs2_data, 32'hA5A5A5A5);
    check_all("bypass");
    tick();

    set_in(0, 0, '0, 1, 3, 3, 3);
    #1 check_all("iss3a");
    tick();
    tick();
    set_in(0, 0, '0, 0, 0, 3, 0);
    #1 chk("sb3.cnt2", {31'b0, rs1_busy}, 32'd1);
    set_in(1, 3, 32'hCAFE0001, 0, 0, 3, 0);
    #1 chk("sb3.wb1", {31'b0, rs1_busy}, 32'd1);
    check_all("sb3.wb1");
    tick();
    set_in(1, 3, 32'hCAFE0002, 0, 0, 3, 0);
    #1 chk("sb3.wb2.busy", {31'b0, rs1_busy}, 32'd0);
    chk("sb3.wb2.data", rs1_data, 32'hCAFE0002);
    tick();

    set_in(0, 0, '0, 1, 9, 0, 0);
    tick();
    set_in(1, 9, 32'h99, 1, 9, 9, 9);
    #1 check_all("sb9.both");
    tick();
    set_in(0, 0, '0, 0, 0, 9, 0);
    #1 chk("sb9.hold", {31'b0, rs1_busy}, 32'd1);
    chk("sb9.noovf", {31'b0, sb_overflow}, 32'd0);
    set_in(0, 0, '0, 1, 9, 9, 0);
    repeat (3) tick();
    set_in(0, 0, '0, 0, 0, 9, 0);
    #1 chk("sb9.ovf", {31'b0, sb_overflow}, 32'd1);
    check_all("sb9.sat");
    tick();
    #1 chk("sb9.sticky", {31'b0, sb_overflow}, 32'd1);

    @(negedge clk);
    set_in(0, 0, '0, 1, 4, 0, 0);
    repeat (2) tick();
    set_in(1, 4, 32'h55, 1, 4, 0, 0);
    tick();
    set_in(0, 0, '0, 0, 0, 4, 4);
    #1 chk("x4.pre.data", rs1_data, 32'h55);
    chk("x4.pre.busy", {31'b0, rs1_busy}, 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("x4.rst.data", rs1_data, 32'h0);
    chk("x4.rst.busy", {31'b0, rs2_busy}, 32'd0);
    check_all("x4.rst");
    tick();
    rst_n = 1'b1;
    set_in(1, 4, 32'h77, 0, 0, 4, 0);
    #1 check_all("x4.wb0");
    tick();
    set_in(0, 0, '0, 1, 4, 4, 0);
    #1 chk("x4.iss.busy", {31'b0, rs1_busy}, 32'd0);
    tick();
    set_in(0, 0, '0, 0, 0, 4, 0);
    #1 chk("x4.cnt1", {31'b0, rs1_busy}, 32'd1);
    chk("x4.data", rs1_data, 32'h77);

    for (int n = 0; n < 400; n++) begin
      set_in(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
             bit'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      #1 check_all("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
